// File: rtl/pp_pipeline_accel_last_blk_pxl_width_calc.sv
// ============================================================================
// Module   : pp_pipeline_accel_last_blk_pxl_width_calc
// Brief    : Runtime last-block pixel width and blocks-per-row calculator with
//            an ap_ctrl_hs handshake and a bit-serial restoring divider.
//            Optional macro PP_LBPW_RESULT_CACHE_EN skips the divide when the
//            request repeats the last legal (cols, nppc) pair.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pp_pipeline_accel_last_blk_pxl_width_calc #(
    parameter  int COL_W    = 16,
    parameter  int MAX_NPPC = 8,
    localparam int NPPC_W   = $clog2(MAX_NPPC + 1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    input  logic              ap_continue,
    input  logic [COL_W-1:0]  cols,
    input  logic [NPPC_W-1:0] nppc,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [NPPC_W-1:0] return_r,
    output logic [COL_W-1:0]  num_blks_r,
    output logic              err_r
);

    localparam int                c_cnt_w    = $clog2(COL_W + 1);
    localparam logic [NPPC_W-1:0] c_max_nppc = NPPC_W'(MAX_NPPC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [COL_W-1:0]    r_dvd;
    logic [NPPC_W:0]     r_rem;
    logic [NPPC_W-1:0]   r_dvs;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_done;
    logic                r_err;
    logic [NPPC_W-1:0]   r_ret;
    logic [COL_W-1:0]    r_nblk;

    logic [NPPC_W+1:0]   w_trial;
    logic [NPPC_W+1:0]   w_dvs_ext;
    logic                w_ge;
    logic [NPPC_W:0]     w_rem_nxt;
    logic [COL_W-1:0]    w_quo_nxt;
    logic                w_rem_nz;
    logic [COL_W-1:0]    w_nblk;
    logic                w_last;
    logic                w_nppc_bad;
    logic                w_cols_zero;
    logic                w_hit;

    // Dividend register doubles as the quotient register: each cycle its MSB
    // shifts into the partial remainder and the new quotient bit enters at the LSB.
    assign w_trial     = {r_rem, r_dvd[COL_W-1]};
    assign w_dvs_ext   = {2'b00, r_dvs};
    assign w_ge        = (w_trial >= w_dvs_ext);
    assign w_rem_nxt   = w_ge ? (NPPC_W+1)'(w_trial - w_dvs_ext) : w_trial[NPPC_W:0];
    assign w_quo_nxt   = {r_dvd[COL_W-2:0], w_ge};
    assign w_rem_nz    = |w_rem_nxt;
    assign w_nblk      = w_quo_nxt + {{(COL_W-1){1'b0}}, w_rem_nz};
    assign w_last      = (r_cnt == c_cnt_w'(1));
    assign w_nppc_bad  = (nppc == '0) || (nppc > c_max_nppc);
    assign w_cols_zero = (cols == '0);

`ifdef PP_LBPW_RESULT_CACHE_EN
    logic              r_cvld;
    logic [COL_W-1:0]  r_ccols;
    logic [NPPC_W-1:0] r_cnppc;

    assign w_hit = r_cvld && (r_ccols == cols) && (r_cnppc == nppc);

    // The pair is captured at acceptance but only marked valid once its
    // divide has completed, so an aborted divide never produces a hit.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_cvld  <= 1'b0;
            r_ccols <= '0;
            r_cnppc <= '0;
        end else if (r_state == S_IDLE && ap_start) begin
            if (w_nppc_bad || w_cols_zero) begin
                r_cvld <= 1'b0;
            end else if (!w_hit) begin
                r_cvld  <= 1'b0;
                r_ccols <= cols;
                r_cnppc <= nppc;
            end
        end else if (r_state == S_CALC && w_last) begin
            r_cvld <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ret   <= '0;
            r_nblk  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_dvs <= nppc;
                        if (w_nppc_bad) begin
                            r_err   <= 1'b1;
                            r_ret   <= '0;
                            r_nblk  <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_cols_zero) begin
                            r_err   <= 1'b0;
                            r_ret   <= '0;
                            r_nblk  <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_hit) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_dvd   <= cols;
                            r_rem   <= '0;
                            r_cnt   <= c_cnt_w'(COL_W);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_dvd <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (w_last) begin
                        r_ret   <= w_rem_nz ? w_rem_nxt[NPPC_W-1:0] : r_dvs;
                        r_nblk  <= w_nblk;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ap_continue) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_done    = r_done;
    assign ap_idle    = (r_state == S_IDLE) && !ap_start;
    assign ap_ready   = (r_state == S_IDLE) && ap_start;
    assign return_r   = r_ret;
    assign num_blks_r = r_nblk;
    assign err_r      = r_err;

endmodule

`default_nettype wire

// File: doc/pp_pipeline_accel_last_blk_pxl_width_calc.md
Name: pp_pipeline_accel_last_blk_pxl_width_calc

Overview:
Runtime successor to the constant last-block-pixel-width return block in the pp_pipeline_accel control path.
- Given image width (cols) and pixels-per-clock (nppc, 1..MAX_NPPC, not restricted to powers of two), computes:
  - the pixel count of the final block of a row;
  - the number of blocks per row.
- Uses an ap_ctrl_hs handshake and a multi-cycle restoring divider.
- Results feed the downstream pixel-packing and line-counting stages.

Parameters:
- COL_W, 16, width of cols and num_blks_r.
- MAX_NPPC, 8, largest legal nppc value.
- NPPC_W, $clog2(MAX_NPPC+1) (localparam), width of nppc and return_r.

Ports:
- ap_clk  in  1  clock; all logic rising-edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  request; sampled only in IDLE.
- ap_continue  in  1  result consumed; releases DONE.
- cols  in  COL_W  image width in pixels; latched at start acceptance.
- nppc  in  NPPC_W  pixels per clock; latched at start acceptance.
- ap_done  out  1  result valid; held until ap_continue.
- ap_idle  out  1  high in IDLE when ap_start is low.
- ap_ready  out  1  one-cycle pulse on start acceptance.
- return_r  out  NPPC_W  last-block width: cols mod nppc, or nppc when the remainder is 0.
- num_blks_r  out  COL_W  ceil(cols/nppc).
- err_r  out  1  illegal nppc on the last request.

Behaviour:
- Reset (ap_rst high, asynchronous): state IDLE; all outputs and internal registers 0; ap_idle recomputes combinationally. Reset asserted mid-CALC or mid-DONE aborts the operation; no ap_done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - ap_ready = ap_start (combinational).
  - On an edge with ap_start=1: latch cols and nppc.
    - nppc==0 or nppc>MAX_NPPC -> DONE; err_r=1; return_r=0; num_blks_r=0.
    - cols==0 -> DONE; err_r=0; return_r=0; num_blks_r=0.
    - Otherwise clear err_r, load the divider, -> CALC.
- CALC:
  - Restoring division, one quotient bit per cycle, MSB first; exactly COL_W cycles.
  - Remainder register is NPPC_W+1 bits; no overflow is possible.
  - On the final cycle, register:
    - return_r = (rem==0) ? nppc : rem;
    - num_blks_r = quotient + (rem!=0), truncated to COL_W bits.
  - Then -> DONE.
- DONE:
  - ap_done=1; ap_start ignored; ap_ready=0.
  - Edge with ap_continue=1 -> IDLE.
  - ap_continue high on the DONE-entry edge has no effect; at least one DONE cycle is always visible.
- Latency (legal request): start accepted at edge 0; ap_done high from cycle COL_W+1. Illegal or zero-width request: ap_done high from cycle 1.
- return_r, num_blks_r and err_r hold their value until the next result is registered, and remain stable in IDLE.
- ap_continue outside DONE is ignored.
- Back-to-back operation: ap_start high through DONE is accepted on the first IDLE cycle after ap_continue.

Optional Feature:
- Macro PP_LBPW_RESULT_CACHE_EN.
- Defined:
  - Keep a valid flag plus the last legal (cols, nppc) pair.
  - A new legal request matching the cached pair skips CALC and goes IDLE -> DONE in one cycle, with outputs unchanged.
  - The valid flag is cleared by reset and by any illegal request.
- Undefined: every legal request takes the full CALC path; no cache registers are present.

Test Plan:
- cols=1920, nppc=8, start pulse -> ap_ready at cycle 0; ap_done from cycle 17; return_r=8; num_blks_r=240; err_r=0.
- cols=1918, nppc=8 -> return_r=6, num_blks_r=240. Then cols=100, nppc=3 -> return_r=1, num_blks_r=34.
- nppc=0, then nppc=9 -> ap_done at cycle 1; err_r=1; return_r=0; num_blks_r=0. Then cols=5, nppc=5 -> err_r=0, return_r=5, num_blks_r=1.
- ap_continue held low for 10 cycles in DONE while ap_start=1 -> ap_done stays 1; ap_ready stays 0; outputs unchanged. ap_continue pulse -> IDLE; new start accepted on the next cycle.
- ap_rst asserted asynchronously at CALC cycle 5 -> state IDLE immediately; all outputs 0; no ap_done. After release, a fresh request completes normally.
- With PP_LBPW_RESULT_CACHE_EN: repeat cols=1920, nppc=8 -> ap_done at cycle 1. A differing request, or any request after an illegal one, takes the full 17-cycle latency.
